// File: rtl/sparc_dp_pkg.sv
// ============================================================================
// Module   : sparc_dp_pkg
// Purpose  : Shared datapath width and destination-select encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sparc_dp_pkg;

  localparam int DP_WIDTH = 32;

  // in_select encodings for the 1:2 steering stage
  localparam logic DEST_RF  = 1'b0;
  localparam logic DEST_AUX = 1'b1;

  typedef logic [DP_WIDTH-1:0] dp_word_t;

endpackage : sparc_dp_pkg

`default_nettype wire

// File: rtl/sync_fifo_32.sv
// ============================================================================
// Module   : sync_fifo_32
// Purpose  : Single-clock FIFO with registered head word; DEPTH power of 2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_32 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  // Self-guarding so a stray push on full or pop on empty cannot corrupt state
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule : sync_fifo_32

`default_nettype wire

// File: rtl/demux1to2_32_buf.sv
// ============================================================================
// Module   : demux1to2_32_buf
// Purpose  : Registered 1:2 steering stage, one FIFO per destination.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux1to2_32_buf
  import sparc_dp_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_select,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out0_valid,
  input  logic                   out0_ready,
  output logic [WIDTH-1:0]       out0_data,
  output logic                   out1_valid,
  input  logic                   out1_ready,
  output logic [WIDTH-1:0]       out1_data,
  output logic [$clog2(DEPTH):0] count0,
  output logic [$clog2(DEPTH):0] count1
);

  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;
  logic pop0, pop1;

  // Ready depends only on registered fullness, never on the consumer readies
  assign in_ready = (in_select == DEST_RF) ? ~full0 : ~full1;

  assign push0 = in_valid & in_ready & (in_select == DEST_RF);
  assign push1 = in_valid & in_ready & (in_select == DEST_AUX);

  assign out0_valid = ~empty0;
  assign out1_valid = ~empty1;
  assign pop0       = out0_valid & out0_ready;
  assign pop1       = out1_valid & out1_ready;

  sync_fifo_32 #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .reset     (reset),
    .push      (push0),
    .push_data (in_data),
    .pop       (pop0),
    .full      (full0),
    .empty     (empty0),
    .count     (count0),
    .head      (out0_data)
  );

  sync_fifo_32 #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .reset     (reset),
    .push      (push1),
    .push_data (in_data),
    .pop       (pop1),
    .full      (full1),
    .empty     (empty1),
    .count     (count1),
    .head      (out1_data)
  );

endmodule : demux1to2_32_buf

`default_nettype wire

// File: tb/tb_demux1to2_32_buf.sv
// ============================================================================
// Module   : tb_demux1to2_32_buf
// Purpose  : Self-checking bench: directed vector table, corner sequences,
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux1to2_32_buf;
  import sparc_dp_pkg::*;

  localparam int W  = 32;
  localparam int D  = 2;
  localparam int CW = $clog2(D) + 1;
  localparam int NV = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_select;
  logic [W-1:0]  in_data;
  logic          out0_valid;
  logic          out0_ready;
  logic [W-1:0]  out0_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [W-1:0]  out1_data;
  logic [CW-1:0] count0;
  logic [CW-1:0] count1;

  int tests    = 0;
  int failures = 0;

  logic          prev_stall = 1'b0;
  logic          prev_sel   = 1'b0;
  logic [W-1:0]  prev_data  = '0;

  typedef struct {
    logic         rst, vld, sel;
    logic [31:0]  data;
    logic         r0, r1;
    logic         chk_rdy, e_rdy;
    logic         e_v0;
    logic [31:0]  e_d0;
    int           e_c0;
    logic         e_v1;
    logic [31:0]  e_d1;
    int           e_c1;
  } vec_t;

  vec_t vecs [NV];

  demux1to2_32_buf #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_select  (in_select),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .count0     (count0),
    .count1     (count1)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rst, vld, sel, input logic [31:0] data, input logic r0, r1,
    input logic chk_rdy, e_rdy,
    input logic e_v0, input logic [31:0] e_d0, input int e_c0,
    input logic e_v1, input logic [31:0] e_d1, input int e_c1);
    vec_t v;
    v.rst = rst; v.vld = vld; v.sel = sel; v.data = data; v.r0 = r0; v.r1 = r1;
    v.chk_rdy = chk_rdy; v.e_rdy = e_rdy;
    v.e_v0 = e_v0; v.e_d0 = e_d0; v.e_c0 = e_c0;
    v.e_v1 = e_v1; v.e_d1 = e_d1; v.e_c1 = e_c1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Applies inputs mid-cycle and enforces the hold-while-stalled rule
  task automatic drive(input logic rst, vld, sel, input logic [31:0] d, input logic r0, r1);
    reset = rst; in_valid = vld; in_select = sel; in_data = d;
    out0_ready = r0; out1_ready = r1;
    #1;
    if (prev_stall && vld && !rst) begin
      assert (sel == prev_sel && d == prev_data)
      else begin
        failures++;
        $display("FAIL hold: stalled input changed sel %0d->%0d data %h->%h",
                 prev_sel, sel, prev_data, d);
      end
    end
    prev_stall = vld && !in_ready && !rst;
    prev_sel   = sel;
    prev_data  = d;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic v0, input logic [31:0] d0, input int c0,
                          input logic v1, input logic [31:0] d1, input int c1);
    chk({tag, " out0_valid"}, 32'(out0_valid), 32'(v0));
    chk({tag, " out0_data"},  out0_data, d0);
    chk({tag, " count0"},     32'(count0), c0);
    chk({tag, " out1_valid"}, 32'(out1_valid), 32'(v1));
    chk({tag, " out1_data"},  out1_data, d1);
    chk({tag, " count1"},     32'(count1), c1);
  endtask

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  initial begin
    //          rst vld sel data          r0 r1 cr rdy  v0 d0            c0  v1 d1            c1
    vecs[0]  = mk(1, 0, 0, 32'h0,        0, 0, 0, 0,  0, 32'h0,        0,  0, 32'h0,        0);
    vecs[1]  = mk(0, 0, 0, 32'h0,        0, 0, 1, 1,  0, 32'h0,        0,  0, 32'h0,        0);
    vecs[2]  = mk(0, 1, 0, 32'h000A0001, 0, 0, 1, 1,  1, 32'h000A0001, 1,  0, 32'h0,        0);
    vecs[3]  = mk(0, 1, 1, 32'h0000BEEF, 0, 0, 1, 1,  1, 32'h000A0001, 1,  1, 32'h0000BEEF, 1);
    vecs[4]  = mk(0, 0, 0, 32'h0,        1, 1, 1, 1,  0, 32'h0,        0,  0, 32'h0,        0);
    vecs[5]  = mk(0, 1, 0, 32'h11111111, 0, 0, 1, 1,  1, 32'h11111111, 1,  0, 32'h0,        0);
    vecs[6]  = mk(0, 1, 0, 32'h22222222, 0, 0, 1, 1,  1, 32'h11111111, 2,  0, 32'h0,        0);
    vecs[7]  = mk(0, 1, 0, 32'h33333333, 0, 0, 1, 0,  1, 32'h11111111, 2,  0, 32'h0,        0);
    vecs[8]  = mk(0, 0, 0, 32'h33333333, 0, 0, 1, 0,  1, 32'h11111111, 2,  0, 32'h0,        0);
    vecs[9]  = mk(0, 1, 1, 32'h44444444, 0, 0, 1, 1,  1, 32'h11111111, 2,  1, 32'h44444444, 1);
    vecs[10] = mk(0, 1, 0, 32'h33333333, 0, 0, 1, 0,  1, 32'h11111111, 2,  1, 32'h44444444, 1);
    vecs[11] = mk(0, 1, 0, 32'h33333333, 1, 0, 1, 0,  1, 32'h22222222, 1,  1, 32'h44444444, 1);
    vecs[12] = mk(0, 1, 0, 32'h33333333, 1, 0, 1, 1,  1, 32'h33333333, 1,  1, 32'h44444444, 1);
    vecs[13] = mk(0, 0, 0, 32'h0,        1, 1, 1, 1,  0, 32'h22222222, 0,  0, 32'h0000BEEF, 0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].sel, vecs[i].data, vecs[i].r0, vecs[i].r1);
      if (vecs[i].chk_rdy)
        chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      clock_edge();
      chk_outs($sformatf("vec%0d", i), vecs[i].e_v0, vecs[i].e_d0, vecs[i].e_c0,
               vecs[i].e_v1, vecs[i].e_d1, vecs[i].e_c1);
    end

    // Streaming through destination 1 across pointer wrap
    drive(0, 1, DEST_AUX, 32'd0, 0, 1);
    clock_edge();
    chk("stream first count1", 32'(count1), 32'd1);
    chk("stream first data1", out1_data, 32'd0);
    for (int i = 1; i < 8; i++) begin
      drive(0, 1, DEST_AUX, i, 0, 1);
      chk($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'd1);
      clock_edge();
      chk($sformatf("stream%0d count1", i), 32'(count1), 32'd1);
      chk($sformatf("stream%0d data1", i), out1_data, i);
    end
    drive(0, 0, DEST_AUX, 32'd0, 0, 1);
    clock_edge();
    chk("stream drain count1", 32'(count1), 32'd0);

    // Reset mid-operation with a push presented in the reset cycle
    drive(0, 1, DEST_RF, 32'hA5A50001, 0, 0);
    clock_edge();
    drive(0, 1, DEST_RF, 32'hA5A50002, 0, 0);
    clock_edge();
    drive(0, 1, DEST_AUX, 32'hA5A50003, 0, 0);
    clock_edge();
    chk("prereset count0", 32'(count0), 32'd2);
    chk("prereset count1", 32'(count1), 32'd1);
    drive(1, 1, DEST_AUX, 32'hDEAD0001, 1, 1);
    clock_edge();
    chk_outs("reset", 0, 32'h0, 0, 0, 32'h0, 0);
    drive(0, 0, DEST_AUX, 32'h0, 0, 0);
    clock_edge();
    chk_outs("postreset", 0, 32'h0, 0, 0, 32'h0, 0);
    chk("postreset in_ready", 32'(in_ready), 32'd1);

    // Randomized traffic against per-destination queues
    for (int n = 0; n < 400; n++) begin
      logic        rst, vld, sel, r0, r1, exp_rdy;
      logic [31:0] d;
      rst = ($urandom_range(0, 49) == 0);
      if (prev_stall) begin
        vld = 1'b1; sel = prev_sel; d = prev_data;
      end else begin
        vld = ($urandom_range(0, 3) != 0);
        sel = 1'($urandom_range(0, 1));
        d   = $urandom;
      end
      r0 = ($urandom_range(0, 2) != 0);
      r1 = 1'($urandom_range(0, 1));
      exp_rdy = sel ? (q1.size() < D) : (q0.size() < D);
      drive(rst, vld, sel, d, r0, r1);
      chk($sformatf("rnd%0d in_ready", n), 32'(in_ready), 32'(exp_rdy));
      clock_edge();
      if (rst) begin
        q0.delete();
        q1.delete();
      end else begin
        if (r0 && q0.size() > 0) void'(q0.pop_front());
        if (r1 && q1.size() > 0) void'(q1.pop_front());
        if (vld && exp_rdy) begin
          if (sel) q1.push_back(d);
          else     q0.push_back(d);
        end
      end
      chk($sformatf("rnd%0d count0", n), 32'(count0), q0.size());
      chk($sformatf("rnd%0d count1", n), 32'(count1), q1.size());
      chk($sformatf("rnd%0d out0_valid", n), 32'(out0_valid), 32'(q0.size() != 0));
      chk($sformatf("rnd%0d out1_valid", n), 32'(out1_valid), 32'(q1.size() != 0));
      if (q0.size() != 0)
        chk($sformatf("rnd%0d out0_data", n), out0_data, q0[0]);
      else if (rst)
        chk($sformatf("rnd%0d out0_data rst", n), out0_data, 32'h0);
      if (q1.size() != 0)
        chk($sformatf("rnd%0d out1_data", n), out1_data, q1[0]);
      else if (rst)
        chk($sformatf("rnd%0d out1_data rst", n), out1_data, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule : tb_demux1to2_32_buf

`default_nettype wire
